// File: rtl/mm_pkg.sv
// Shared types and encodings for the matching-memory front end.
// Entry field widths are fixed here, so mm_match TAG_W/DATA_W must keep their defaults.
package mm_pkg;

  localparam int unsigned EntryTagW  = 8;
  localparam int unsigned EntryDataW = 16;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;
  localparam logic EXB_PASS = 1'b1;
  localparam logic EXB_DEL  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StOut
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [EntryTagW-1:0]  tag;
    logic                  lr;
    logic [EntryDataW-1:0] data;
  } entry_t;

endpackage

// File: rtl/mm_cam.sv
// Combinational associative search over the waiting-token table.
// Finds the lowest-index partner (same tag, opposite side) and the lowest free entry.
module mm_cam
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0]     tab_i,
  input  logic   [EntryTagW-1:0] tag_i,
  input  logic                   lr_i,
  output logic                   hit_o,
  output logic   [IdxW-1:0]      hit_idx_o,
  output logic                   free_any_o,
  output logic   [IdxW-1:0]      free_idx_o
);

  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    free_any_o = 1'b0;
    free_idx_o = '0;
    // Scan downwards so the last assignment is the lowest index.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (tab_i[i].valid && (tab_i[i].tag == tag_i) && (tab_i[i].lr != lr_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IdxW'(i);
      end
      if (!tab_i[i].valid) begin
        free_any_o = 1'b1;
        free_idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/mm_match.sv
// Matching-memory front end: pairs left/right operand tokens by tag and forwards
// either the matched pair (exb=1) or the lone stored token (exb=0) downstream.
module mm_match
  import mm_pkg::*;
#(
  parameter int unsigned TAG_W  = EntryTagW,
  parameter int unsigned DATA_W = EntryDataW,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned IdxW  = $clog2(DEPTH),
  localparam int unsigned OccW  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              in_send,
  output logic              in_ack,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_lr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_send,
  input  logic              out_ack,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_ldata,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_exb,
  output logic [OccW-1:0]   occupancy,
  output logic              ovf_err
);

  state_e              state_q;
  entry_t [DEPTH-1:0]  tab_q;
  logic   [TAG_W-1:0]  reg_tag_q;
  logic                reg_lr_q;
  logic   [DATA_W-1:0] reg_data_q;
  logic                in_ack_q;
  logic                out_send_q;
  logic   [TAG_W-1:0]  out_tag_q;
  logic   [DATA_W-1:0] out_ldata_q;
  logic   [DATA_W-1:0] out_rdata_q;
  logic                out_exb_q;
  logic   [OccW-1:0]   occ_q;
  logic                ovf_q;

  logic                hit;
  logic   [IdxW-1:0]   hit_idx;
  logic                free_any;
  logic   [IdxW-1:0]   free_idx;

  mm_cam #(
    .DEPTH(DEPTH)
  ) u_cam (
    .tab_i      (tab_q),
    .tag_i      (reg_tag_q),
    .lr_i       (reg_lr_q),
    .hit_o      (hit),
    .hit_idx_o  (hit_idx),
    .free_any_o (free_any),
    .free_idx_o (free_idx)
  );

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_q     <= StIdle;
      tab_q       <= '0;
      reg_tag_q   <= '0;
      reg_lr_q    <= LR_LEFT;
      reg_data_q  <= '0;
      in_ack_q    <= 1'b0;
      out_send_q  <= 1'b0;
      out_tag_q   <= '0;
      out_ldata_q <= '0;
      out_rdata_q <= '0;
      out_exb_q   <= EXB_DEL;
      occ_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_send && in_ack_q) begin
            reg_tag_q  <= in_tag;
            reg_lr_q   <= in_lr;
            reg_data_q <= in_data;
            in_ack_q   <= 1'b0;
            state_q    <= StLookup;
          end else begin
            // Raises in_ack on the first edge after reset is released.
            in_ack_q <= 1'b1;
          end
        end
        StLookup: begin
          out_tag_q  <= reg_tag_q;
          out_send_q <= 1'b1;
          state_q    <= StOut;
          if (hit) begin
            tab_q[hit_idx].valid <= 1'b0;
            out_exb_q            <= EXB_PASS;
            occ_q                <= occ_q - OccW'(1);
            if (reg_lr_q == LR_LEFT) begin
              out_ldata_q <= reg_data_q;
              out_rdata_q <= tab_q[hit_idx].data;
            end else begin
              out_ldata_q <= tab_q[hit_idx].data;
              out_rdata_q <= reg_data_q;
            end
          end else begin
            out_exb_q   <= EXB_DEL;
            out_ldata_q <= (reg_lr_q == LR_LEFT) ? reg_data_q : '0;
            out_rdata_q <= (reg_lr_q == LR_RIGHT) ? reg_data_q : '0;
            if (free_any) begin
              tab_q[free_idx] <= '{valid: 1'b1, tag: reg_tag_q, lr: reg_lr_q, data: reg_data_q};
              occ_q           <= occ_q + OccW'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        StOut: begin
          if (out_ack) begin
            out_send_q <= 1'b0;
            in_ack_q   <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ack    = in_ack_q;
  assign out_send  = out_send_q;
  assign out_tag   = out_tag_q;
  assign out_ldata = out_ldata_q;
  assign out_rdata = out_rdata_q;
  assign out_exb   = out_exb_q;
  assign occupancy = occ_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mm_match.sv
// Self-checking bench for mm_match: directed vector table, reset corner case,
// then random tokens checked against a slot-level reference model.
module tb_mm_match;

  logic        CLK = 1'b0;
  logic        MR;
  logic        in_send;
  logic        in_ack;
  logic [7:0]  in_tag;
  logic        in_lr;
  logic [15:0] in_data;
  logic        out_send;
  logic        out_ack;
  logic [7:0]  out_tag;
  logic [15:0] out_ldata;
  logic [15:0] out_rdata;
  logic        out_exb;
  logic [3:0]  occupancy;
  logic        ovf_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  mm_match dut (
    .CLK       (CLK),
    .MR        (MR),
    .in_send   (in_send),
    .in_ack    (in_ack),
    .in_tag    (in_tag),
    .in_lr     (in_lr),
    .in_data   (in_data),
    .out_send  (out_send),
    .out_ack   (out_ack),
    .out_tag   (out_tag),
    .out_ldata (out_ldata),
    .out_rdata (out_rdata),
    .out_exb   (out_exb),
    .occupancy (occupancy),
    .ovf_err   (ovf_err)
  );

  typedef struct {
    logic [7:0]  tag;
    logic        lr;
    logic [15:0] data;
    int          hold;
    logic        exb;
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  occ;
    logic        ovf;
  } vec_t;

  vec_t tv[$];

  // Reference model: slot array searched by the matching rules.
  logic        m_v[8];
  logic [7:0]  m_tag[8];
  logic        m_lr[8];
  logic [15:0] m_data[8];
  logic        m_ovf;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] tag, input logic lr, input logic [15:0] data,
                            output logic exb, output logic [15:0] l, output logic [15:0] r,
                            output logic [3:0] occ, output logic ovf);
    int hit = -1;
    int fr  = -1;
    for (int i = 0; i < 8; i++) begin
      if (hit < 0 && m_v[i] && m_tag[i] == tag && m_lr[i] != lr) hit = i;
      if (fr < 0 && !m_v[i]) fr = i;
    end
    if (hit >= 0) begin
      m_v[hit] = 1'b0;
      exb = 1'b1;
      l   = lr ? m_data[hit] : data;
      r   = lr ? data : m_data[hit];
    end else begin
      exb = 1'b0;
      l   = lr ? 16'h0 : data;
      r   = lr ? data : 16'h0;
      if (fr >= 0) begin
        m_v[fr] = 1'b1; m_tag[fr] = tag; m_lr[fr] = lr; m_data[fr] = data;
      end else begin
        m_ovf = 1'b1;
      end
    end
    occ = 4'd0;
    for (int i = 0; i < 8; i++) occ += {3'b0, m_v[i]};
    ovf = m_ovf;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic exb, input logic [7:0] tag,
                         input logic [15:0] l, input logic [15:0] r,
                         input logic [3:0] occ, input logic ovf);
    chk({nm, ".exb"}, 32'(out_exb), 32'(exb));
    chk({nm, ".tag"}, 32'(out_tag), 32'(tag));
    chk({nm, ".ldata"}, 32'(out_ldata), 32'(l));
    chk({nm, ".rdata"}, 32'(out_rdata), 32'(r));
    chk({nm, ".occ"}, 32'(occupancy), 32'(occ));
    chk({nm, ".ovf"}, 32'(ovf_err), 32'(ovf));
  endtask

  // One token through the block; called on a negedge, returns on a negedge.
  task automatic xfer(input string nm, input logic [7:0] tag, input logic lr,
                      input logic [15:0] data, input int hold, input logic exb,
                      input logic [15:0] l, input logic [15:0] r,
                      input logic [3:0] occ, input logic ovf);
    int w = 0;
    while (in_ack !== 1'b1 && w < 10) begin
      @(negedge CLK);
      w++;
    end
    chk({nm, ".in_ack_ready"}, 32'(in_ack), 32'd1);
    in_send = 1'b1; in_tag = tag; in_lr = lr; in_data = data; out_ack = 1'b0;
    @(negedge CLK);
    in_send = 1'b0;
    chk({nm, ".lookup_in_ack"}, 32'(in_ack), 32'd0);
    chk({nm, ".lookup_out_send"}, 32'(out_send), 32'd0);
    @(negedge CLK);
    chk({nm, ".out_send_latency"}, 32'(out_send), 32'd1);
    chk_out(nm, exb, tag, l, r, occ, ovf);
    for (int c = 0; c < hold; c++) begin
      @(negedge CLK);
      chk({nm, ".hold_out_send"}, 32'(out_send), 32'd1);
      chk({nm, ".hold_in_ack"}, 32'(in_ack), 32'd0);
      chk_out({nm, ".hold"}, exb, tag, l, r, occ, ovf);
    end
    out_ack = 1'b1;
    @(negedge CLK);
    out_ack = 1'b0;
    chk({nm, ".acked_out_send"}, 32'(out_send), 32'd0);
    chk({nm, ".acked_in_ack"}, 32'(in_ack), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_exb, e_ovf;
    logic [15:0] e_l, e_r;
    logic [3:0]  e_occ;
    logic [7:0]  rt;
    logic        rl;
    logic [15:0] rd;
    int          rh;

    MR = 1'b1; in_send = 1'b0; in_tag = '0; in_lr = 1'b0; in_data = '0; out_ack = 1'b0;
    model_clear();

    tv.push_back('{8'h12, 1'b0, 16'h00AA, 0, 1'b0, 16'h00AA, 16'h0000, 4'd1, 1'b0});
    tv.push_back('{8'h12, 1'b1, 16'h0055, 0, 1'b1, 16'h00AA, 16'h0055, 4'd0, 1'b0});
    tv.push_back('{8'h07, 1'b0, 16'h0001, 0, 1'b0, 16'h0001, 16'h0000, 4'd1, 1'b0});
    tv.push_back('{8'h07, 1'b0, 16'h0002, 0, 1'b0, 16'h0002, 16'h0000, 4'd2, 1'b0});
    tv.push_back('{8'h07, 1'b1, 16'h0003, 0, 1'b1, 16'h0001, 16'h0003, 4'd1, 1'b0});
    for (int i = 0; i < 7; i++) begin
      tv.push_back('{8'h20 + 8'(i), 1'b0, 16'h0100 + 16'(i), 0, 1'b0, 16'h0100 + 16'(i),
                     16'h0000, 4'(i + 2), 1'b0});
    end
    tv.push_back('{8'h99, 1'b0, 16'h0999, 0, 1'b0, 16'h0999, 16'h0000, 4'd8, 1'b1});
    tv.push_back('{8'h20, 1'b1, 16'h0BEE, 0, 1'b1, 16'h0100, 16'h0BEE, 4'd7, 1'b1});
    tv.push_back('{8'h07, 1'b1, 16'h0004, 0, 1'b1, 16'h0002, 16'h0004, 4'd6, 1'b1});
    tv.push_back('{8'h30, 1'b1, 16'h0005, 0, 1'b0, 16'h0000, 16'h0005, 4'd7, 1'b1});
    tv.push_back('{8'h30, 1'b1, 16'h0007, 0, 1'b0, 16'h0000, 16'h0007, 4'd8, 1'b1});
    tv.push_back('{8'h30, 1'b0, 16'h0006, 5, 1'b1, 16'h0006, 16'h0005, 4'd7, 1'b1});

    repeat (2) @(negedge CLK);
    chk("reset.in_ack", 32'(in_ack), 32'd0);
    chk("reset.out_send", 32'(out_send), 32'd0);
    chk_out("reset", 1'b0, 8'h00, 16'h0, 16'h0, 4'd0, 1'b0);
    MR = 1'b0;
    @(negedge CLK);
    chk("post_reset.in_ack", 32'(in_ack), 32'd1);

    foreach (tv[i]) begin
      xfer($sformatf("vec%0d", i), tv[i].tag, tv[i].lr, tv[i].data, tv[i].hold,
           tv[i].exb, tv[i].l, tv[i].r, tv[i].occ, tv[i].ovf);
    end

    // Reset asserted while a token is in the lookup cycle.
    in_send = 1'b1; in_tag = 8'h44; in_lr = 1'b0; in_data = 16'h4444;
    @(negedge CLK);
    in_send = 1'b0;
    chk("mr_pre.occ", 32'(occupancy), 32'd7);
    MR = 1'b1;
    #1;
    chk("mr.out_send", 32'(out_send), 32'd0);
    chk("mr.occ", 32'(occupancy), 32'd0);
    chk("mr.ovf", 32'(ovf_err), 32'd0);
    chk("mr.in_ack", 32'(in_ack), 32'd0);
    @(negedge CLK);
    MR = 1'b0;
    #1;
    chk("mr_release.in_ack", 32'(in_ack), 32'd0);
    @(negedge CLK);
    chk("mr_edge.in_ack", 32'(in_ack), 32'd1);
    chk("mr_edge.out_send", 32'(out_send), 32'd0);
    model_clear();

    // Random tokens from a small tag pool so hits, duplicates and stores all occur.
    for (int i = 0; i < 80; i++) begin
      rt = 8'h50 + 8'($urandom_range(0, 3));
      rl = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      rh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model_step(rt, rl, rd, e_exb, e_l, e_r, e_occ, e_ovf);
      xfer($sformatf("rnd%0d", i), rt, rl, rd, rh, e_exb, e_l, e_r, e_occ, e_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
